// File: rtl/i2c_accel_target.sv
// I2C register-access target for an accelerometer-style register file.
// Raw SCL/SDA are synchronised and glitch-filtered.  A two-process FSM then
// decodes START/STOP, the device address, a register pointer, and data bytes.
// Register-file side: reg_wr is a one-cycle strobe with reg_addr/reg_wdata
// valid in the same cycle.  reg_rd is a one-cycle request with reg_addr
// valid in the same cycle.  reg_rdata is captured exactly one cycle after
// reg_rd, so there is no back-pressure on either strobe.
`timescale 1ns/1ps

module i2c_accel_target #(
    parameter logic [6:0] DEV_ADDR = 7'h1D,
    parameter int         FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic [3:0] dbg_state
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ADDR     = 4'd1,
        S_ADDR_ACK = 4'd2,
        S_PTR      = 4'd3,
        S_PTR_ACK  = 4'd4,
        S_WR       = 4'd5,
        S_WR_ACK   = 4'd6,
        S_RD       = 4'd7,
        S_RD_ACK   = 4'd8,
        S_IGNORE   = 4'd9
    } state_t;

    // Bit 1 carries SCL and bit 0 carries SDA through the input conditioning.
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_filt;
    logic [1:0]    r_filt_d;
    logic [CW-1:0] r_cnt [2];

    logic w_scl_f;
    logic w_sda_f;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    // FSM and datapath registers
    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_ptr;
    logic [7:0] r_tx;
    logic       r_rw;
    logic       r_phase;
    logic       r_rd_d;
    logic       r_sda_oe;
    logic       r_reg_wr;
    logic       r_reg_rd;
    logic [7:0] r_reg_addr;
    logic [7:0] r_reg_wdata;
    logic       r_busy;

    // Next-state values
    state_t     w_state_nxt;
    logic [3:0] w_bit_cnt_nxt;
    logic [7:0] w_shift_nxt;
    logic [7:0] w_ptr_nxt;
    logic [7:0] w_tx_nxt;
    logic       w_rw_nxt;
    logic       w_phase_nxt;
    logic       w_sda_oe_nxt;
    logic       w_reg_wr_nxt;
    logic       w_reg_rd_nxt;
    logic [7:0] w_reg_addr_nxt;
    logic [7:0] w_reg_wdata_nxt;
    logic       w_busy_nxt;

    logic [7:0] w_rx_byte;
    logic [7:0] w_ptr_inc;

    // Two-stage synchroniser, then accept a new level only after FILT_LEN
    // consecutive samples disagree with the current filtered level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= 2'b11;
            r_sync2  <= 2'b11;
            r_filt   <= 2'b11;
            r_filt_d <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1  <= {scl_i, sda_i};
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(FILT_LEN - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_scl_f    = r_filt[1];
    assign w_sda_f    = r_filt[0];
    assign w_scl_rise = w_scl_f & ~r_filt_d[1];
    assign w_scl_fall = ~w_scl_f & r_filt_d[1];
    // START/STOP need SCL high in both the current and the previous sample,
    // so an SDA edge that lines up with an SCL edge is never taken as one.
    assign w_start    = w_scl_f & r_filt_d[1] & r_filt_d[0] & ~w_sda_f;
    assign w_stop     = w_scl_f & r_filt_d[1] & ~r_filt_d[0] & w_sda_f;

    // Byte as it stands once the bit sampled on this SCL rise is shifted in.
    assign w_rx_byte  = {r_shift[6:0], w_sda_f};
    assign w_ptr_inc  = r_ptr + 8'd1;

    // FSM state and datapath register update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'h00;
            r_ptr       <= 8'h00;
            r_tx        <= 8'h00;
            r_rw        <= 1'b0;
            r_phase     <= 1'b0;
            r_rd_d      <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_reg_addr  <= 8'h00;
            r_reg_wdata <= 8'h00;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_ptr       <= w_ptr_nxt;
            r_tx        <= w_tx_nxt;
            r_rw        <= w_rw_nxt;
            r_phase     <= w_phase_nxt;
            r_rd_d      <= r_reg_rd;
            r_sda_oe    <= w_sda_oe_nxt;
            r_reg_wr    <= w_reg_wr_nxt;
            r_reg_rd    <= w_reg_rd_nxt;
            r_reg_addr  <= w_reg_addr_nxt;
            r_reg_wdata <= w_reg_wdata_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state logic.  In the ACK states r_phase is 0 until the fall that
    // ends bit 8 (which starts the ACK drive).  It is 1 until the fall that
    // ends the 9th clock.  In RD_ACK, r_phase records that the master ACKed.
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_ptr_nxt       = r_ptr;
        w_tx_nxt        = r_rd_d ? reg_rdata : r_tx;
        w_rw_nxt        = r_rw;
        w_phase_nxt     = r_phase;
        w_sda_oe_nxt    = r_sda_oe;
        w_reg_wr_nxt    = 1'b0;
        w_reg_rd_nxt    = 1'b0;
        w_reg_addr_nxt  = r_reg_addr;
        w_reg_wdata_nxt = r_reg_wdata;
        w_busy_nxt      = r_busy;

        if (w_start) begin
            w_state_nxt   = S_ADDR;
            w_bit_cnt_nxt = 4'd0;
            w_phase_nxt   = 1'b0;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
        end else if (w_stop) begin
            w_state_nxt  = S_IDLE;
            w_phase_nxt  = 1'b0;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sda_oe_nxt = 1'b0;
                end

                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_rx_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_bit_cnt_nxt = 4'd0;
                            if (w_rx_byte[7:1] == DEV_ADDR) begin
                                w_state_nxt = S_ADDR_ACK;
                                w_phase_nxt = 1'b0;
                                w_rw_nxt    = w_rx_byte[0];
                                w_busy_nxt  = 1'b1;
                                // Prefetch the first read byte during the ACK.
                                if (w_rx_byte[0]) begin
                                    w_reg_rd_nxt   = 1'b1;
                                    w_reg_addr_nxt = r_ptr;
                                end
                            end else begin
                                w_state_nxt = S_IGNORE;
                            end
                        end
                    end
                end

                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_sda_oe_nxt = 1'b1;
                            w_phase_nxt  = 1'b1;
                        end else begin
                            w_phase_nxt   = 1'b0;
                            w_bit_cnt_nxt = 4'd0;
                            if (r_rw) begin
                                w_state_nxt  = S_RD;
                                w_sda_oe_nxt = ~r_tx[7];
                            end else begin
                                w_state_nxt  = S_PTR;
                                w_sda_oe_nxt = 1'b0;
                            end
                        end
                    end
                end

                S_PTR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_rx_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_bit_cnt_nxt = 4'd0;
                            w_ptr_nxt     = w_rx_byte;
                            w_state_nxt   = S_PTR_ACK;
                            w_phase_nxt   = 1'b0;
                        end
                    end
                end

                S_WR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_rx_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        // Only a complete byte is written; an abort earlier
                        // leaves the register file and pointer untouched.
                        if (r_bit_cnt == 4'd7) begin
                            w_bit_cnt_nxt   = 4'd0;
                            w_reg_wr_nxt    = 1'b1;
                            w_reg_addr_nxt  = r_ptr;
                            w_reg_wdata_nxt = w_rx_byte;
                            w_ptr_nxt       = w_ptr_inc;
                            w_state_nxt     = S_WR_ACK;
                            w_phase_nxt     = 1'b0;
                        end
                    end
                end

                S_PTR_ACK, S_WR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_sda_oe_nxt = 1'b1;
                            w_phase_nxt  = 1'b1;
                        end else begin
                            w_sda_oe_nxt  = 1'b0;
                            w_phase_nxt   = 1'b0;
                            w_bit_cnt_nxt = 4'd0;
                            w_state_nxt   = S_WR;
                        end
                    end
                end

                S_RD: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_sda_oe_nxt  = 1'b0;
                            w_bit_cnt_nxt = 4'd0;
                            w_phase_nxt   = 1'b0;
                            w_state_nxt   = S_RD_ACK;
                        end else begin
                            w_tx_nxt     = {r_tx[6:0], 1'b0};
                            w_sda_oe_nxt = ~r_tx[6];
                        end
                    end
                end

                S_RD_ACK: begin
                    if (w_scl_rise) begin
                        if (!w_sda_f) begin
                            w_ptr_nxt      = w_ptr_inc;
                            w_reg_rd_nxt   = 1'b1;
                            w_reg_addr_nxt = w_ptr_inc;
                            w_phase_nxt    = 1'b1;
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end else if (w_scl_fall && r_phase) begin
                        w_phase_nxt   = 1'b0;
                        w_bit_cnt_nxt = 4'd0;
                        w_sda_oe_nxt  = ~r_tx[7];
                        w_state_nxt   = S_RD;
                    end
                end

                S_IGNORE: begin
                    w_sda_oe_nxt = 1'b0;
                end

                default: begin
                    w_state_nxt  = S_IDLE;
                    w_sda_oe_nxt = 1'b0;
                    w_busy_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe    = r_sda_oe;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_wr    = r_reg_wr;
    assign reg_rd    = r_reg_rd;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_i2c_accel_target.sv
// Directed bench for i2c_accel_target: a bit-level I2C master, an open-drain
// bus model, a synchronous register-file model and a write scoreboard.
`timescale 1ns/1ps

module tb_i2c_accel_target;

  localparam int H = 10;  // quarter SCL period in clk cycles (SCL = clk/40)

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  logic       glitch;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       busy;
  logic [3:0] dbg_state;

  logic [7:0]  mem [256];
  logic [15:0] act_wr_q[$];
  logic [7:0]  act_rd_q[$];
  logic [15:0] exp_q[$];
  int          oe_cnt;
  int          busy_cnt;
  int          n_checks;
  int          n_pass;

  // clock / reset block
  always #5 clk = ~clk;

  assign sda_line = sda_m & ~sda_oe & ~glitch;

  i2c_accel_target #(.DEV_ADDR(7'h1D), .FILT_LEN(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // register file: read data appears the cycle after reg_rd
  always @(posedge clk) begin
    if (reg_rd) reg_rdata <= mem[reg_addr];
  end

  // bus monitor, sampled away from the active edge
  initial begin
    oe_cnt = 0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (reg_wr) act_wr_q.push_back({reg_addr, reg_wdata});
      if (reg_rd) act_rd_q.push_back(reg_addr);
      if (sda_oe) oe_cnt++;
      if (busy) busy_cnt++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    else n_pass++;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver tasks
  task automatic i2c_start();
    if (scl_m == 1'b0) begin
      wait_clk(H); sda_m = 1'b1;
      wait_clk(H); scl_m = 1'b1;
    end
    wait_clk(2*H); sda_m = 1'b0;
    wait_clk(2*H); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(H); sda_m = 1'b0;
    wait_clk(H); scl_m = 1'b1;
    wait_clk(2*H); sda_m = 1'b1;
    wait_clk(2*H);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    wait_clk(H); sda_m = b;
    wait_clk(H); scl_m = 1'b1;
    wait_clk(H); s = sda_line;
    wait_clk(H); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(nack, s);
  endtask

  // scoreboard: compare writes since base against exp_q, then empty it
  task automatic check_writes(input string tag, input int base);
    check({tag, "_wr_count"}, 32'(act_wr_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && (base + i) < act_wr_q.size(); i++)
      check({tag, "_wr"}, 32'(act_wr_q[base + i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  initial begin
    logic       ack;
    logic [7:0] d0;
    logic [7:0] d1;
    int         wr_base;
    int         rd_base;
    int         oe_base;
    int         busy_base;
    int         non_idle;

    n_checks = 0;
    n_pass = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h2E] = 8'hC7;
    mem[8'h32] = 8'h5A;
    mem[8'h33] = 8'hA5;
    mem[8'h40] = 8'h00;

    // reset state
    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; glitch = 1'b0;
    wait_clk(5);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_reg_wr", 32'(reg_wr), 32'd0);
    check("rst_reg_rd", 32'(reg_rd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'h00);
    check("rst_reg_wdata", 32'(reg_wdata), 32'h00);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    wait_clk(10);

    // single register write
    wr_base = act_wr_q.size();
    i2c_start();
    send_byte(8'h3A, ack); check("s32_addr_ack", 32'(ack), 32'd0);
    check("s32_busy", 32'(busy), 32'd1);
    send_byte(8'h2D, ack); check("s32_ptr_ack", 32'(ack), 32'd0);
    send_byte(8'h08, ack); check("s32_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    check("s32_busy_after_stop", 32'(busy), 32'd0);
    check("s32_state_idle", 32'(dbg_state), 32'd0);
    exp_q.push_back({8'h2D, 8'h08});
    check_writes("s32", wr_base);

    // pointer left at 0x2E: read one byte from it
    rd_base = act_rd_q.size();
    i2c_start();
    send_byte(8'h3B, ack); check("ptr_addr_ack", 32'(ack), 32'd0);
    read_byte(1'b1, d0);
    i2c_stop();
    check("ptr_rd_count", 32'(act_rd_q.size() - rd_base), 32'd1);
    if (act_rd_q.size() > rd_base) check("ptr_rd_addr", 32'(act_rd_q[rd_base]), 32'h2E);
    check("ptr_rd_data", 32'(d0), 32'hC7);

    // pointer write, repeated START, two-byte read
    wr_base = act_wr_q.size();
    rd_base = act_rd_q.size();
    i2c_start();
    send_byte(8'h3A, ack); check("s33_waddr_ack", 32'(ack), 32'd0);
    send_byte(8'h32, ack); check("s33_ptr_ack", 32'(ack), 32'd0);
    i2c_start();
    send_byte(8'h3B, ack); check("s33_raddr_ack", 32'(ack), 32'd0);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    i2c_stop();
    check("s33_byte0", 32'(d0), 32'h5A);
    check("s33_byte1", 32'(d1), 32'hA5);
    check("s33_rd_count", 32'(act_rd_q.size() - rd_base), 32'd2);
    if (act_rd_q.size() >= rd_base + 2) begin
      check("s33_rd_addr0", 32'(act_rd_q[rd_base]), 32'h32);
      check("s33_rd_addr1", 32'(act_rd_q[rd_base + 1]), 32'h33);
    end
    check_writes("s33", wr_base);

    // foreign address stays passive
    wr_base = act_wr_q.size();
    rd_base = act_rd_q.size();
    oe_base = oe_cnt;
    busy_base = busy_cnt;
    i2c_start();
    send_byte(8'h30, ack); check("s34_addr_nack", 32'(ack), 32'd1);
    send_byte(8'h55, ack); check("s34_data_nack", 32'(ack), 32'd1);
    i2c_stop();
    check("s34_oe_cycles", 32'(oe_cnt - oe_base), 32'd0);
    check("s34_busy_cycles", 32'(busy_cnt - busy_base), 32'd0);
    check("s34_rd_count", 32'(act_rd_q.size() - rd_base), 32'd0);
    check_writes("s34", wr_base);

    // pointer wrap 0xFF -> 0x00
    wr_base = act_wr_q.size();
    i2c_start();
    send_byte(8'h3A, ack); check("s35_addr_ack", 32'(ack), 32'd0);
    send_byte(8'hFF, ack); check("s35_ptr_ack", 32'(ack), 32'd0);
    send_byte(8'h11, ack); check("s35_d0_ack", 32'(ack), 32'd0);
    send_byte(8'h22, ack); check("s35_d1_ack", 32'(ack), 32'd0);
    i2c_stop();
    exp_q.push_back({8'hFF, 8'h11});
    exp_q.push_back({8'h00, 8'h22});
    check_writes("s35", wr_base);

    // STOP after 4 data bits: no write, pointer kept at 0x40
    wr_base = act_wr_q.size();
    i2c_start();
    send_byte(8'h3A, ack); check("s36_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h40, ack); check("s36_ptr_ack", 32'(ack), 32'd0);
    clock_bit(1'b1, ack);
    clock_bit(1'b1, ack);
    clock_bit(1'b0, ack);
    clock_bit(1'b0, ack);
    i2c_stop();
    check("s36_state_idle", 32'(dbg_state), 32'd0);
    check_writes("s36", wr_base);
    rd_base = act_rd_q.size();
    i2c_start();
    send_byte(8'h3B, ack); check("s36_raddr_ack", 32'(ack), 32'd0);
    read_byte(1'b1, d0);
    i2c_stop();
    check("s36_rd_count", 32'(act_rd_q.size() - rd_base), 32'd1);
    if (act_rd_q.size() > rd_base) check("s36_ptr_kept", 32'(act_rd_q[rd_base]), 32'h40);

    // one-cycle SDA glitch on an idle bus is not a START
    wait_clk(20);
    glitch = 1'b1;
    wait_clk(1);
    glitch = 1'b0;
    non_idle = 0;
    for (int k = 0; k < 30; k++) begin
      wait_clk(1);
      if (dbg_state != 4'd0) non_idle++;
    end
    check("s36_glitch_no_start", 32'(non_idle), 32'd0);
    check("s36_glitch_busy", 32'(busy), 32'd0);

    // reset while the target drives a 0 read bit
    i2c_start();
    send_byte(8'h3B, ack); check("s37_raddr_ack", 32'(ack), 32'd0);
    for (int k = 0; k < 200 && !sda_oe; k++) wait_clk(1);
    check("s37_driving", 32'(sda_oe), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("s37_async_release", 32'(sda_oe), 32'd0);
    check("s37_rst_state", 32'(dbg_state), 32'd0);
    wait_clk(3);
    reset = 1'b0;
    wait_clk(10);
    oe_base = oe_cnt;
    send_byte(8'h3A, ack);
    check("s37_no_start_nack", 32'(ack), 32'd1);
    check("s37_no_start_oe", 32'(oe_cnt - oe_base), 32'd0);
    wr_base = act_wr_q.size();
    i2c_start();
    send_byte(8'h3A, ack); check("s37_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h50, ack); check("s37_ptr_ack", 32'(ack), 32'd0);
    send_byte(8'h77, ack); check("s37_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    exp_q.push_back({8'h50, 8'h77});
    check_writes("s37", wr_base);
    check("s37_state_idle", 32'(dbg_state), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_accel_target.md
I2C_ACCEL_TARGET -- requirements
Module: i2c_accel_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1D, meaning the 7-bit I2C device address this target answers to.
REQ-002 SHALL have parameter FILT_LEN, default 3, meaning the number of consecutive equal synchronized samples needed to accept a new SCL/SDA level.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-005 SHALL have port scl_i, input, 1 bit, the raw I2C clock pin level, asynchronous to clk.
REQ-006 SHALL have port sda_i, input, 1 bit, the raw I2C data pin level, asynchronous to clk.
REQ-007 SHALL have port sda_oe, output, 1 bit; 1 pulls SDA low, 0 releases it (open-drain).
REQ-008 SHALL have port reg_addr, output, 8 bits, the register pointer presented to the register file.
REQ-009 SHALL have port reg_wdata, output, 8 bits, the write data; valid while reg_wr=1.
REQ-010 SHALL have port reg_wr, output, 1 bit, a one-cycle write strobe.
REQ-011 SHALL have port reg_rd, output, 1 bit, a one-cycle read request.
REQ-012 SHALL have port reg_rdata, input, 8 bits, the read data; sampled exactly 1 cycle after reg_rd.
REQ-013 SHALL have port busy, output, 1 bit, which is 1 from address match until STOP or START.

Function
REQ-014 SHALL pass scl_i/sda_i through a 2-FF synchronizer, then a FILT_LEN-sample glitch filter; all decoding uses the filtered levels scl_f/sda_f.
REQ-015 SHALL detect START as a falling sda_f while scl_f=1, and STOP as a rising sda_f while scl_f=1; SCL rise and SCL fall are single-cycle events.
REQ-016 SHALL sample SDA on the SCL rise event, and SHALL change sda_oe only in the cycle after an SCL fall event.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
REQ-018 SHALL go from any state to ADDR on START (repeated START included), with bit counter cleared and sda_oe=0.
REQ-019 SHALL go from any state to IDLE on STOP, with sda_oe=0 and busy=0.
REQ-020 SHALL, in ADDR, shift in 8 bits MSB first; if bits[7:1]==DEV_ADDR it SHALL enter ADDR_ACK and drive sda_oe=1 for the 9th clock, otherwise it SHALL enter IGNORE (SDA never driven).
REQ-021 SHALL, on a write address (R/W=0), follow ADDR_ACK with PTR; the received byte loads the pointer, is ACKed in PTR_ACK, and leads to WR.
REQ-022 SHALL ACK each WR byte (WR_ACK); on the SCL rise of that byte's 8th bit it SHALL assert reg_wr for 1 cycle with reg_addr=pointer and reg_wdata=byte, then increment the pointer.
REQ-023 SHALL, on a read address (R/W=1), pulse reg_rd during ADDR_ACK with reg_addr=pointer, latch reg_rdata the following cycle into the TX shift register, and drive bit 7 after the ACK's SCL fall.
REQ-024 SHALL, in RD, drive sda_oe = ~tx_bit for 8 bits; in RD_ACK it SHALL release SDA and sample the master's bit.
REQ-025 SHALL, when the RD_ACK sample is 0 (ACK), increment the pointer, pulse reg_rd with the new pointer, reload, and return to RD; when it is 1 (NACK), it SHALL enter IGNORE.
REQ-026 SHALL let the pointer wrap 8'hFF -> 8'h00 with no error indication.
REQ-027 SHALL treat STOP or START arriving mid-byte as aborting the byte: no reg_wr for a partial byte, and the pointer is kept.
REQ-028 SHALL keep IGNORE passive (sda_oe=0, no strobes) until START or STOP.
REQ-029 SHALL not stretch clocks; clk SHALL be at least 16x the SCL rate.

Reset
REQ-030 SHALL, while reset=1, hold state=IDLE, sda_oe=0, reg_wr=0, reg_rd=0, busy=0, reg_addr=8'h00, reg_wdata=8'h00, with synchronizer/filter outputs at 1.
REQ-031 SHALL, on reset asserted mid-transfer, release SDA immediately (asynchronously); after deassertion it SHALL ignore bus traffic until the next START.

Verification
REQ-032 SHALL pass this scenario: write 0x3A, ptr 0x2D, data 0x08, STOP -> 3 ACKs; one reg_wr with reg_addr=0x2D, reg_wdata=0x08; pointer ends at 0x2E.
REQ-033 SHALL pass this scenario: write 0x3A, ptr 0x32, Sr, 0x3B, read 2 bytes (ACK then NACK), with reg_rdata = 0x5A@0x32 and 0xA5@0x33 -> SDA carries 0x5A then 0xA5; exactly 2 reg_rd pulses.
REQ-034 SHALL pass this scenario: address 0x30 -> no ACK, sda_oe=0 throughout, busy=0, no strobes.
REQ-035 SHALL pass this scenario: ptr 0xFF, write 0x11, 0x22 -> reg_wr to 0xFF then to 0x00.
REQ-036 SHALL pass this scenario: STOP after 4 data bits of a write byte -> no reg_wr, state IDLE; 1-cycle SDA glitch with FILT_LEN=3 -> no START is detected.
REQ-037 SHALL pass this scenario: reset pulse while driving a read bit 0 -> sda_oe=0 within the same cycle; the next full transaction completes normally.
